apb_write_master_arb: RTL and testbench

APB_WRITE_MASTER_ARB -- requirements
Module: apb_write_master_arb

---
 rtl/apb_ctrl_pkg.sv | 21 ++
 rtl/apb_write_master_arb_if.sv | 21 ++
 rtl/apb_rr_arb2.sv | 30 +++
 rtl/apb_write_master_arb.sv | 140 ++++++++++++++
 tb/tb_apb_write_master_arb.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_ctrl_pkg.sv
// Shared definitions for the APB write master: FSM state encoding, default
// PREADY timeout and small address/owner helpers.
package apb_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   localparam int TIMEOUT_DEFAULT = 15;

   function automatic logic addr_is_aligned(input logic [31:0] addr);
      return (addr[1:0] == 2'b00);
   endfunction

   function automatic logic [1:0] owner_onehot(input logic owner);
      return owner ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/apb_write_master_arb_if.sv
// APB write-only bus bundle between the master and a single slave.
interface apb_write_master_arb_if;

   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PADDR;
   logic [31:0] PWDATA;
   logic        PREADY;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PREADY
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PREADY
   );

endinterface

// File: rtl/apb_rr_arb2.sv
// Two-input round-robin arbiter: contention goes to the requester that did
// not win last; the pointer only moves when a grant is actually issued.
module apb_rr_arb2 (
   input  logic       PCLK,
   input  logic       PRESETn,
   input  logic [1:0] req,
   input  logic       gnt_en,
   output logic [1:0] gnt
);

   logic last_reg;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_gnt
         // Win when alone, or when the other side was served last time.
         assign gnt[gi] = gnt_en & req[gi] &
                          (~req[1-gi] | (last_reg != 1'(gi)));
      end
   endgenerate

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         last_reg <= 1'b1;
      end else if (|gnt) begin
         last_reg <= gnt[1];
      end
   end

endmodule

// File: rtl/apb_write_master_arb.sv
// APB write master shared by two requesters, with misaligned-address
// rejection and a PREADY wait timeout.
module apb_write_master_arb
   import apb_ctrl_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic        PCLK,
   input  logic        PRESETn,
   input  logic        req0_valid,
   input  logic [31:0] req0_addr,
   input  logic [31:0] req0_wdata,
   output logic        req0_ready,
   output logic        req0_done,
   output logic        req0_err,
   input  logic        req1_valid,
   input  logic [31:0] req1_addr,
   input  logic [31:0] req1_wdata,
   output logic        req1_ready,
   output logic        req1_done,
   output logic        req1_err,
   apb_write_master_arb_if.master apb
);

   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   apb_state_e  state_reg, state_next;
   logic [1:0]  req_valid, gnt;
   logic [1:0]  ready_reg, done_reg, err_reg;
   logic        owner_reg;
   logic        gnt_en, gnt_any, addr_ok, time_out, xfer_end;
   logic [31:0] sel_addr, sel_wdata;
   logic [31:0] paddr_reg, pwdata_reg;
   logic [7:0]  wait_cnt_reg;

   assign req_valid = {req1_valid, req0_valid};
   // While a ready pulse is out the requester may still show valid for the
   // request just taken, so hold off granting for that cycle.
   assign gnt_en    = (state_reg == IDLE) && (ready_reg == 2'b00);

   apb_rr_arb2 u_arb (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .req     (req_valid),
      .gnt_en  (gnt_en),
      .gnt     (gnt)
   );

   assign gnt_any   = |gnt;
   assign sel_addr  = gnt[1] ? req1_addr  : req0_addr;
   assign sel_wdata = gnt[1] ? req1_wdata : req0_wdata;
   assign addr_ok   = addr_is_aligned(sel_addr);

   // PREADY on the edge that would hit the limit still counts as success.
   assign time_out = (state_reg == ACCESS) && !apb.PREADY &&
                     ((wait_cnt_reg + 8'd1) == TIMEOUT_CNT);
   assign xfer_end = (state_reg == ACCESS) && (apb.PREADY || time_out);

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE:    if (gnt_any && addr_ok) state_next = SETUP;
         SETUP:   state_next = ACCESS;
         ACCESS:  if (xfer_end) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      apb.PSEL    = 1'b0;
      apb.PENABLE = 1'b0;
      apb.PWRITE  = 1'b0;
      unique case (state_reg)
         SETUP: begin
            apb.PSEL   = 1'b1;
            apb.PWRITE = 1'b1;
         end
         ACCESS: begin
            apb.PSEL    = 1'b1;
            apb.PENABLE = 1'b1;
            apb.PWRITE  = 1'b1;
         end
         default: ;
      endcase
   end

   assign apb.PADDR  = paddr_reg;
   assign apb.PWDATA = pwdata_reg;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         ready_reg    <= '0;
         done_reg     <= '0;
         err_reg      <= '0;
         owner_reg    <= 1'b0;
         paddr_reg    <= '0;
         pwdata_reg   <= '0;
         wait_cnt_reg <= '0;
      end else begin
         ready_reg <= gnt;
         done_reg  <= '0;
         err_reg   <= '0;
         if (gnt_any) begin
            if (addr_ok) begin
               paddr_reg  <= sel_addr;
               pwdata_reg <= sel_wdata;
               owner_reg  <= gnt[1];
            end else begin
               done_reg <= gnt;
               err_reg  <= gnt;
            end
         end
         if (xfer_end) begin
            done_reg <= owner_onehot(owner_reg);
            err_reg  <= time_out ? owner_onehot(owner_reg) : 2'b00;
         end
         if (state_reg == SETUP) begin
            wait_cnt_reg <= '0;
         end else if ((state_reg == ACCESS) && !apb.PREADY) begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
         end
      end
   end

   assign req0_ready = ready_reg[0];
   assign req1_ready = ready_reg[1];
   assign req0_done  = done_reg[0];
   assign req1_done  = done_reg[1];
   assign req0_err   = err_reg[0];
   assign req1_err   = err_reg[1];

endmodule

// File: tb/tb_apb_write_master_arb.sv
// Directed bench for apb_write_master_arb (TIMEOUT=4) with a small APB slave
// memory model and a bus monitor that logs grants and completions.
module tb_apb_write_master_arb;
   import apb_ctrl_pkg::*;

   logic        PCLK = 1'b0;
   logic        PRESETn;
   logic        req0_valid, req1_valid;
   logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
   logic        req0_ready, req0_done, req0_err;
   logic        req1_ready, req1_done, req1_err;

   apb_write_master_arb_if bus ();

   apb_write_master_arb #(.TIMEOUT(4)) dut (
      .PCLK       (PCLK),
      .PRESETn    (PRESETn),
      .req0_valid (req0_valid),
      .req0_addr  (req0_addr),
      .req0_wdata (req0_wdata),
      .req0_ready (req0_ready),
      .req0_done  (req0_done),
      .req0_err   (req0_err),
      .req1_valid (req1_valid),
      .req1_addr  (req1_addr),
      .req1_wdata (req1_wdata),
      .req1_ready (req1_ready),
      .req1_done  (req1_done),
      .req1_err   (req1_err),
      .apb        (bus)
   );

   always #5 PCLK = ~PCLK;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int wait_n   = 0;
   int acc_n;
   logic [31:0] mem [0:63];

   int grant_q [$];
   int done_q  [$];
   int ready_cyc, done_cyc, rise_cyc, pen_cyc;
   int psel_rise, access_cycles, clash, pwrite_bad, err_orphan;
   logic psel_prev = 1'b0, pen_prev = 1'b0;
   logic [31:0] rise_paddr, rise_pwdata;
   logic rise_pen, rise_pwrite;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   always @(posedge PCLK) cyc++;

   // Slave: PREADY rises once wait_n ACCESS cycles have passed.
   initial begin
      bus.PREADY = 1'b0;
      acc_n = 0;
      forever begin
         @(negedge PCLK);
         if (bus.PSEL && bus.PENABLE) begin
            acc_n++;
            bus.PREADY = (acc_n > wait_n);
         end else begin
            acc_n = 0;
            bus.PREADY = 1'b0;
         end
      end
   end

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = '0;
      forever begin
         @(posedge PCLK);
         if (bus.PSEL && bus.PENABLE && bus.PREADY) mem[bus.PADDR[7:2]] = bus.PWDATA;
      end
   end

   always @(negedge PCLK) begin
      if (req0_ready || req1_ready) begin
         ready_cyc = cyc;
         grant_q.push_back(req1_ready ? 1 : 0);
      end
      if (req0_ready && req1_ready) clash++;
      if (req0_done && req1_done) clash++;
      if ((req0_err && !req0_done) || (req1_err && !req1_done)) err_orphan++;
      if (req0_done || req1_done) begin
         done_cyc = cyc;
         done_q.push_back(req1_done ? (1 + 2 * int'(req1_err)) : (2 * int'(req0_err)));
         $display("txn: req%0d done err=%0d paddr=0x%08h cycle=%0d",
                  req1_done ? 1 : 0, req1_done ? req1_err : req0_err, bus.PADDR, cyc);
      end
      if (bus.PSEL && !psel_prev) begin
         psel_rise++;
         rise_cyc    = cyc;
         rise_paddr  = bus.PADDR;
         rise_pwdata = bus.PWDATA;
         rise_pen    = bus.PENABLE;
         rise_pwrite = bus.PWRITE;
      end
      if (bus.PENABLE && !pen_prev) pen_cyc = cyc;
      if (bus.PSEL && bus.PENABLE) access_cycles++;
      if (bus.PWRITE !== bus.PSEL) pwrite_bad++;
      psel_prev = bus.PSEL;
      pen_prev  = bus.PENABLE;
   end

   task automatic clear_log();
      grant_q.delete();
      done_q.delete();
      psel_rise = 0;
      access_cycles = 0;
   endtask

   task automatic put_req(input int n, input logic [31:0] a, input logic [31:0] d);
      int k;
      logic seen;
      if (n == 0) begin
         req0_valid = 1'b1; req0_addr = a; req0_wdata = d;
      end else begin
         req1_valid = 1'b1; req1_addr = a; req1_wdata = d;
      end
      k = 0;
      seen = 1'b0;
      while (!seen && k < 300) begin
         @(negedge PCLK);
         k++;
         seen = (n == 0) ? req0_ready : req1_ready;
      end
      check_eq($sformatf("ready_req%0d", n), 32'(seen), 32'd1);
      if (n == 0) req0_valid = 1'b0;
      else        req1_valid = 1'b0;
   endtask

   task automatic wait_dones(input int target);
      int k = 0;
      while (done_q.size() < target && k < 600) begin
         @(negedge PCLK);
         k++;
      end
      check_eq("done_count", done_q.size(), target);
   endtask

   task automatic check_outputs_zero(input string tag);
      check_eq({tag, "_psel"},    32'(bus.PSEL),    32'd0);
      check_eq({tag, "_penable"}, 32'(bus.PENABLE), 32'd0);
      check_eq({tag, "_pwrite"},  32'(bus.PWRITE),  32'd0);
      check_eq({tag, "_paddr"},   bus.PADDR,        32'd0);
      check_eq({tag, "_pwdata"},  bus.PWDATA,       32'd0);
      check_eq({tag, "_req_out"}, 32'({req0_ready, req0_done, req0_err,
                                       req1_ready, req1_done, req1_err}), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      PRESETn = 1'b0;
      req0_valid = 1'b0; req0_addr = '0; req0_wdata = '0;
      req1_valid = 1'b0; req1_addr = '0; req1_wdata = '0;
      repeat (2) @(negedge PCLK);
      check_outputs_zero("reset");
      PRESETn = 1'b1;
      @(negedge PCLK);

      // Single write, PREADY on the 4th ACCESS cycle (also the timeout boundary).
      clear_log();
      wait_n = 3;
      put_req(0, 32'h10, 32'hA5A50001);
      wait_dones(1);
      check_eq("single_psel_with_ready", rise_cyc, ready_cyc);
      check_eq("single_setup_penable", 32'(rise_pen), 32'd0);
      check_eq("single_setup_pwrite", 32'(rise_pwrite), 32'd1);
      check_eq("single_setup_paddr", rise_paddr, 32'h10);
      check_eq("single_setup_pwdata", rise_pwdata, 32'hA5A50001);
      check_eq("single_penable_cycle", pen_cyc, rise_cyc + 1);
      check_eq("single_access_cycles", access_cycles, 4);
      check_eq("single_done_cycle", done_cyc, pen_cyc + 4);
      check_eq("single_done_entry", done_q[0], 0);
      check_eq("single_mem4", mem[4], 32'hA5A50001);
      check_eq("single_psel_after", 32'(bus.PSEL), 32'd0);
      check_eq("single_paddr_hold", bus.PADDR, 32'h10);

      // Contention from reset: req0 first.
      PRESETn = 1'b0;
      repeat (2) @(negedge PCLK);
      PRESETn = 1'b1;
      clear_log();
      wait_n = 0;
      fork
         put_req(0, 32'h20, 32'h11111111);
         put_req(1, 32'h24, 32'h22222222);
      join
      wait_dones(2);
      check_eq("contend_grants", grant_q.size(), 2);
      for (int i = 0; i < grant_q.size(); i++)
         check_eq($sformatf("contend_grant%0d", i), grant_q[i], i);
      check_eq("contend_mem8", mem[8], 32'h11111111);
      check_eq("contend_mem9", mem[9], 32'h22222222);

      // Fairness: both continuously valid for 6 transfers.
      clear_log();
      fork
         begin
            for (int i = 0; i < 3; i++) put_req(0, 32'h80 + 32'(8 * i), 32'hF0F00000 + 32'(i));
         end
         begin
            for (int i = 0; i < 3; i++) put_req(1, 32'h84 + 32'(8 * i), 32'h0F0F0000 + 32'(i));
         end
      join
      wait_dones(6);
      check_eq("fair_grants", grant_q.size(), 6);
      for (int i = 0; i < grant_q.size(); i++)
         check_eq($sformatf("fair_grant%0d", i), grant_q[i], i % 2);
      check_eq("fair_mem37", mem[37], 32'h0F0F0002);

      // Misaligned request from req1.
      clear_log();
      put_req(1, 32'h13, 32'hDEAD0013);
      repeat (4) @(negedge PCLK);
      check_eq("mis_grants", grant_q.size(), 1);
      check_eq("mis_dones", done_q.size(), 1);
      check_eq("mis_done_entry", done_q[0], 3);
      check_eq("mis_same_cycle", done_cyc, ready_cyc);
      check_eq("mis_psel_rise", psel_rise, 0);

      // Timeout with PREADY never asserted, then a normal transfer.
      clear_log();
      wait_n = 255;
      put_req(0, 32'h30, 32'h30303030);
      wait_dones(1);
      check_eq("to_access_cycles", access_cycles, 4);
      check_eq("to_done_entry", done_q[0], 2);
      check_eq("to_psel_after", 32'(bus.PSEL), 32'd0);
      check_eq("to_mem12", mem[12], 32'd0);
      clear_log();
      wait_n = 0;
      put_req(1, 32'h34, 32'h34343434);
      wait_dones(1);
      check_eq("after_to_done_entry", done_q[0], 1);
      check_eq("after_to_mem13", mem[13], 32'h34343434);

      // Reset in ACCESS: outputs drop at once, no completion afterwards.
      clear_log();
      wait_n = 255;
      put_req(0, 32'h38, 32'h38383838);
      k = 0;
      while (!bus.PENABLE && k < 20) begin
         @(negedge PCLK);
         k++;
      end
      check_eq("rst_reached_access", 32'(bus.PENABLE), 32'd1);
      @(negedge PCLK);
      #2 PRESETn = 1'b0;
      #1 check_outputs_zero("rst_async");
      repeat (2) @(negedge PCLK);
      PRESETn = 1'b1;
      wait_n = 0;
      repeat (5) @(negedge PCLK);
      check_eq("rst_no_done", done_q.size(), 0);
      clear_log();
      fork
         put_req(0, 32'h3C, 32'h3C3C3C3C);
         put_req(1, 32'h40, 32'h40404040);
      join
      wait_dones(2);
      check_eq("rst_first_grant", grant_q[0], 0);
      check_eq("rst_mem15", mem[15], 32'h3C3C3C3C);

      check_eq("no_dual_pulse", clash, 0);
      check_eq("pwrite_tracks_psel", pwrite_bad, 0);
      check_eq("err_only_with_done", err_orphan, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
